// File: rtl/float_pkg.sv
// Shared definitions for the inverse-square-root float stages: constants, FSM
// state encoding and IEEE-754 single field-extract helpers.
package float_pkg;

    localparam logic [7:0]  BIAS              = 8'd127;
    localparam logic [31:0] THREE_HALVES_Q131 = 32'hC000_0000;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ALIGN  = 3'd1;
    localparam logic [2:0] S_SUB    = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_MUL    = 3'd4;
    localparam logic [2:0] S_OVF    = 3'd5;
    localparam logic [2:0] S_ROUND  = 3'd6;
    localparam logic [2:0] S_FINISH = 3'd7;

    function automatic logic f_sign(input logic [31:0] f);
        return f[31];
    endfunction

    function automatic logic [7:0] f_exp(input logic [31:0] f);
        return f[30:23];
    endfunction

    function automatic logic [22:0] f_mant(input logic [31:0] f);
        return f[22:0];
    endfunction

endpackage

// File: rtl/float_nr_step_lzc32.sv
// Combinational 32-bit leading-zero counter; an all-zero input reports 32.
module lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scanning upward lets the most significant set bit win.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) count = 6'(31 - i);
        end
    end

endmodule

// File: rtl/float_nr_step.sv
// Newton-Raphson update y' = y * (1.5 - 0.5 * p) for the inverse-square-root
// datapath, as a fixed 7-cycle FSM with a start/ready handshake.
module float_nr_step
    import float_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] float_in_y,
    input  logic [31:0] float_in_p,
    output logic [31:0] float_out,
    output logic        ready,
    output logic        busy
);

    logic [2:0]  state_q, state_d;
    logic [7:0]  e_y_q, e_y_d, e_p_q, e_p_d;
    logic [22:0] m_y_q, m_y_d, m_p_q, m_p_d;
    logic        zero_q, zero_d;
    logic [31:0] h_fx_q, h_fx_d, t_q, t_d;
    logic [23:0] t_n_q, t_n_d;
    logic [9:0]  e_q, e_d;
    logic [25:0] prod_q, prod_d;
    logic [22:0] mant_q, mant_d;
    logic [31:0] float_out_q, float_out_d;
    logic        ready_q, ready_d;

    logic [5:0]  lz;
    logic [31:0] t_shift;
    logic [7:0]  shamt;
    logic [47:0] mul_full;
    logic [23:0] m_sum;
    logic        unused_bits;

    lzc32 u_lzc (
        .value (t_q),
        .count (lz)
    );

    // prod_q keeps product bits [47:22]: overflow bit, hidden bit, mantissa, guard.
    assign t_shift  = t_q << lz;
    assign shamt    = (BIAS + 8'd1) - e_p_q;
    assign mul_full = {24'd0, 1'b1, m_y_q} * {24'd0, t_n_q};
    assign m_sum    = {1'b0, prod_q[23:1]} + {23'd0, prod_q[0]};

    assign unused_bits = ^{f_sign(float_in_y), f_sign(float_in_p), mul_full[21:0], t_shift[7:0]};

    always_comb begin
        state_d     = state_q;
        e_y_d       = e_y_q;
        e_p_d       = e_p_q;
        m_y_d       = m_y_q;
        m_p_d       = m_p_q;
        zero_d      = zero_q;
        h_fx_d      = h_fx_q;
        t_d         = t_q;
        t_n_d       = t_n_q;
        e_d         = e_q;
        prod_d      = prod_q;
        mant_d      = mant_q;
        float_out_d = float_out_q;
        ready_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    e_y_d   = f_exp(float_in_y);
                    m_y_d   = f_mant(float_in_y);
                    e_p_d   = f_exp(float_in_p);
                    m_p_d   = f_mant(float_in_p);
                    zero_d  = 1'b0;
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // h = p/2 reaches 1.5 once its exponent is positive or its top mantissa bit is set.
                zero_d = (e_p_q > BIAS + 8'd1) || ((e_p_q == BIAS + 8'd1) && m_p_q[22]);
                if (e_p_q == 8'd0)             h_fx_d = 32'd0;
                else if (e_p_q >= BIAS + 8'd1) h_fx_d = {1'b1, m_p_q, 8'd0};
                else if (shamt >= 8'd32)       h_fx_d = 32'd0;
                else                           h_fx_d = {1'b1, m_p_q, 8'd0} >> shamt[4:0];
                state_d = S_SUB;
            end
            S_SUB: begin
                t_d = THREE_HALVES_Q131 - h_fx_q;
                if (t_d == 32'd0) zero_d = 1'b1;
                state_d = S_NORM;
            end
            S_NORM: begin
                t_n_d   = t_shift[31:8];
                e_d     = {2'b00, e_y_q} - {4'b0000, lz};
                state_d = S_MUL;
            end
            S_MUL: begin
                prod_d  = mul_full[47:22];
                state_d = S_OVF;
            end
            S_OVF: begin
                if (prod_q[25]) begin
                    prod_d = {1'b0, prod_q[25:1]};
                    e_d    = e_q + 10'd1;
                end
                state_d = S_ROUND;
            end
            S_ROUND: begin
                mant_d = m_sum[23] ? 23'd0 : m_sum[22:0];
                if (m_sum[23]) e_d = e_q + 10'd1;
                state_d = S_FINISH;
            end
            S_FINISH: begin
                if (zero_q || (e_y_q == 8'd0) || ($signed(e_q) <= 10'sd0))
                    float_out_d = 32'h0000_0000;
                else if ($signed(e_q) >= 10'sd255)
                    float_out_d = 32'h7F80_0000;
                else
                    float_out_d = {1'b0, e_q[7:0], mant_q};
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            e_y_q       <= '0;
            e_p_q       <= '0;
            m_y_q       <= '0;
            m_p_q       <= '0;
            zero_q      <= 1'b0;
            h_fx_q      <= '0;
            t_q         <= '0;
            t_n_q       <= '0;
            e_q         <= '0;
            prod_q      <= '0;
            mant_q      <= '0;
            float_out_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            e_y_q       <= e_y_d;
            e_p_q       <= e_p_d;
            m_y_q       <= m_y_d;
            m_p_q       <= m_p_d;
            zero_q      <= zero_d;
            h_fx_q      <= h_fx_d;
            t_q         <= t_d;
            t_n_q       <= t_n_d;
            e_q         <= e_d;
            prod_q      <= prod_d;
            mant_q      <= mant_d;
            float_out_q <= float_out_d;
            ready_q     <= ready_d;
        end
    end

    assign float_out = float_out_q;
    assign ready     = ready_q;
    assign busy      = (state_q != S_IDLE);

endmodule
